// File: rtl/branch_predictor_unit_if.sv
// Purpose: signal bundle between the fetch/execute pipeline stages and the
//          branch predictor unit.
// Ports (modport view of the predictor = slave):
//   Pc_F, prediction_F, target_F                 fetch-side lookup
//   update_E, Pc_E, real_Value_E, target_E,
//   prediction_E, predTarget_E                   EX-side branch resolution
//   flush, correct_Pc, selectCorrectPcPlus1      mispredict redirect
//   branch_cnt, mispred_cnt                      statistics
interface branch_predictor_unit_if #(
    parameter int PC_W   = 5,
    parameter int STAT_W = 16
);
    logic [PC_W-1:0]   Pc_F;
    logic              prediction_F;
    logic [PC_W-1:0]   target_F;
    logic              update_E;
    logic [PC_W-1:0]   Pc_E;
    logic              real_Value_E;
    logic [PC_W-1:0]   target_E;
    logic              prediction_E;
    logic [PC_W-1:0]   predTarget_E;
    logic              flush;
    logic [PC_W-1:0]   correct_Pc;
    logic              selectCorrectPcPlus1;
    logic [STAT_W-1:0] branch_cnt;
    logic [STAT_W-1:0] mispred_cnt;

    modport master (
        output Pc_F, update_E, Pc_E, real_Value_E, target_E, prediction_E, predTarget_E,
        input  prediction_F, target_F, flush, correct_Pc, selectCorrectPcPlus1,
               branch_cnt, mispred_cnt
    );

    modport slave (
        input  Pc_F, update_E, Pc_E, real_Value_E, target_E, prediction_E, predTarget_E,
        output prediction_F, target_F, flush, correct_Pc, selectCorrectPcPlus1,
               branch_cnt, mispred_cnt
    );
endinterface

// File: rtl/branch_predictor_unit.sv
// Purpose: fetch-side dynamic branch predictor. A table of 2-bit saturating
//          counters plus a direct-mapped target buffer, both indexed by the
//          full PC. Lookup is combinational for IF; training happens on the
//          clock edge when EX resolves a branch. Mispredicts raise flush and
//          the corrected PC combinationally. Saturating statistics counters
//          track resolved branches and mispredictions.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    branch_predictor_unit_if.slave (lookup, resolve, redirect, stats)
module branch_predictor_unit #(
    parameter int         PC_W     = 5,
    parameter logic [1:0] INIT_CNT = 2'b01,
    parameter int         STAT_W   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    branch_predictor_unit_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** PC_W;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt_e;

    // Tables are packed so the whole array can be cleared in one reset assignment.
    logic [DEPTH-1:0][1:0]      r_cnt;
    logic [DEPTH-1:0]           r_valid;
    logic [DEPTH-1:0][PC_W-1:0] r_btb;
    logic [STAT_W-1:0]          r_branch_cnt;
    logic [STAT_W-1:0]          r_mispred_cnt;

    cnt_e w_cnt_F;
    cnt_e w_cnt_E;
    cnt_e w_cnt_next;
    logic w_mis;

    // Lookup reads the registered table, so a same-cycle update is not visible.
    assign w_cnt_F          = cnt_e'(r_cnt[bus.Pc_F]);
    assign bus.prediction_F = r_valid[bus.Pc_F] & ((w_cnt_F == WT) | (w_cnt_F == ST));
    assign bus.target_F     = r_btb[bus.Pc_F];

    // A predicted-taken branch with the right direction but a stale target still mispredicts.
    assign w_mis = bus.update_E &
                   ((bus.prediction_E != bus.real_Value_E) |
                    (bus.prediction_E & bus.real_Value_E & (bus.predTarget_E != bus.target_E)));

    assign bus.flush                = w_mis;
    assign bus.correct_Pc           = bus.real_Value_E ? bus.target_E : bus.Pc_E + PC_W'(1);
    assign bus.selectCorrectPcPlus1 = w_mis & ~bus.real_Value_E;
    assign bus.branch_cnt           = r_branch_cnt;
    assign bus.mispred_cnt          = r_mispred_cnt;

    // Next state of the counter being trained.
    assign w_cnt_E = cnt_e'(r_cnt[bus.Pc_E]);

    always_comb begin
        w_cnt_next = w_cnt_E;
        if (bus.real_Value_E) begin
            unique case (w_cnt_E)
                SNT: w_cnt_next = WNT;
                WNT: w_cnt_next = WT;
                WT:  w_cnt_next = ST;
                ST:  w_cnt_next = ST;
            endcase
        end else begin
            unique case (w_cnt_E)
                SNT: w_cnt_next = SNT;
                WNT: w_cnt_next = SNT;
                WT:  w_cnt_next = WNT;
                ST:  w_cnt_next = WT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt         <= {DEPTH{INIT_CNT}};
            r_valid       <= '0;
            r_btb         <= '0;
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (bus.update_E) begin
                r_cnt[bus.Pc_E] <= w_cnt_next;
                if (bus.real_Value_E) begin
                    r_btb[bus.Pc_E]   <= bus.target_E;
                    r_valid[bus.Pc_E] <= 1'b1;
                end
                if (r_branch_cnt != '1) begin
                    r_branch_cnt <= r_branch_cnt + STAT_W'(1);
                end
            end
            if (w_mis && (r_mispred_cnt != '1)) begin
                r_mispred_cnt <= r_mispred_cnt + STAT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_branch_predictor_unit.sv
module tb_branch_predictor_unit;
    localparam int PC_W   = 5;
    localparam int STAT_W = 16;

    logic clk = 1'b0;
    logic reset;

    branch_predictor_unit_if #(.PC_W(PC_W), .STAT_W(STAT_W)) bus ();

    branch_predictor_unit #(
        .PC_W    (PC_W),
        .INIT_CNT(2'b01),
        .STAT_W  (STAT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    string       q_tag[$];
    logic [31:0] q_val[$];

    task automatic push(input string tag, input logic [31:0] v);
        q_tag.push_back(tag);
        q_val.push_back(v);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        string       tag;
        logic [31:0] exp_v;
        n_checks++;
        if (q_val.size() == 0) begin
            n_errors++;
            $error("FAIL scoreboard_empty: observed=%0h expected=<none>", obs);
        end else begin
            tag   = q_tag.pop_front();
            exp_v = q_val.pop_front();
            assert (obs === exp_v) else begin
                n_errors++;
                $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
            end
        end
    endtask

    // Expectation pushers / observers for each output group.
    task automatic exp_f(input string lbl, input logic pred, input logic [4:0] tgt);
        push({lbl, ".prediction_F"}, 32'(pred));
        push({lbl, ".target_F"}, 32'(tgt));
    endtask
    task automatic chk_f();
        pop_check(32'(bus.prediction_F));
        pop_check(32'(bus.target_F));
    endtask

    task automatic exp_e(input string lbl, input logic fl, input logic [4:0] cpc, input logic sel);
        push({lbl, ".flush"}, 32'(fl));
        push({lbl, ".correct_Pc"}, 32'(cpc));
        push({lbl, ".selectCorrectPcPlus1"}, 32'(sel));
    endtask
    task automatic chk_e();
        pop_check(32'(bus.flush));
        pop_check(32'(bus.correct_Pc));
        pop_check(32'(bus.selectCorrectPcPlus1));
    endtask

    task automatic exp_s(input string lbl, input logic [15:0] b, input logic [15:0] m);
        push({lbl, ".branch_cnt"}, 32'(b));
        push({lbl, ".mispred_cnt"}, 32'(m));
    endtask
    task automatic chk_s();
        pop_check(32'(bus.branch_cnt));
        pop_check(32'(bus.mispred_cnt));
    endtask

    task automatic upd(input logic [4:0] pc, input logic real_v, input logic [4:0] tgt,
                       input logic pred, input logic [4:0] ptgt);
        bus.update_E     = 1'b1;
        bus.Pc_E         = pc;
        bus.real_Value_E = real_v;
        bus.target_E     = tgt;
        bus.prediction_E = pred;
        bus.predTarget_E = ptgt;
    endtask

    task automatic idle();
        bus.update_E     = 1'b0;
        bus.Pc_E         = '0;
        bus.real_Value_E = 1'b0;
        bus.target_E     = '0;
        bus.prediction_E = 1'b0;
        bus.predTarget_E = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset  = 1'b1;
        bus.Pc_F = '0;
        idle();

        // 1: reset state
        @(negedge clk);
        exp_f("rst_hold", 1'b0, 5'd0);
        exp_e("rst_hold", 1'b0, 5'd1, 1'b0);
        exp_s("rst_hold", 16'd0, 16'd0);
        #1; chk_f(); chk_e(); chk_s();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            bus.Pc_F = 5'(i);
            exp_f($sformatf("sweep%0d", i), 1'b0, 5'd0);
            #1; chk_f();
        end
        exp_s("sweep", 16'd0, 16'd0);
        chk_s();

        // 2: cold taken branch at 4 -> 12
        @(negedge clk);
        upd(5'd4, 1'b1, 5'd12, 1'b0, 5'd0);
        exp_e("t2_upd", 1'b1, 5'd12, 1'b0);
        #1; chk_e();
        @(negedge clk);
        idle();
        bus.Pc_F = 5'd4;
        exp_f("t2_look", 1'b1, 5'd12);
        exp_s("t2_stats", 16'd1, 16'd1);
        #1; chk_f(); chk_s();

        // 3: train 4 to strongly taken, then two not-taken mispredicts
        @(negedge clk);
        upd(5'd4, 1'b1, 5'd12, 1'b1, 5'd12);
        exp_e("t3_correct", 1'b0, 5'd12, 1'b0);
        #1; chk_e();
        @(negedge clk);
        upd(5'd4, 1'b0, 5'd12, 1'b1, 5'd12);
        exp_e("t3_nt1", 1'b1, 5'd5, 1'b1);
        #1; chk_e();
        @(negedge clk);
        idle();
        exp_f("t3_after_nt1", 1'b1, 5'd12);
        #1; chk_f();
        @(negedge clk);
        upd(5'd4, 1'b0, 5'd12, 1'b1, 5'd12);
        @(negedge clk);
        idle();
        exp_f("t3_after_nt2", 1'b0, 5'd12);
        exp_s("t3_stats", 16'd4, 16'd3);
        #1; chk_f(); chk_s();

        // 4: PC wrap, wrong target, correct not-taken, idle with junk inputs
        @(negedge clk);
        upd(5'd31, 1'b0, 5'd17, 1'b1, 5'd17);
        exp_e("t4_wrap", 1'b1, 5'd0, 1'b1);
        #1; chk_e();
        @(negedge clk);
        upd(5'd7, 1'b1, 5'd10, 1'b1, 5'd9);
        exp_e("t4_tgt", 1'b1, 5'd10, 1'b0);
        #1; chk_e();
        @(negedge clk);
        upd(5'd10, 1'b0, 5'd3, 1'b0, 5'd3);
        exp_e("t4_nt_ok", 1'b0, 5'd11, 1'b0);
        #1; chk_e();
        @(negedge clk);
        idle();
        bus.Pc_E         = 5'd20;
        bus.prediction_E = 1'b1;
        bus.real_Value_E = 1'b0;
        bus.Pc_F         = 5'd7;
        exp_e("t4_noupd", 1'b0, 5'd21, 1'b0);
        exp_f("t4_look7", 1'b1, 5'd10);
        #1; chk_e(); chk_f();
        @(negedge clk);
        idle();
        bus.Pc_F = 5'd31;
        exp_f("t4_look31", 1'b0, 5'd0);
        exp_s("t4_stats", 16'd7, 16'd5);
        #1; chk_f(); chk_s();

        // 5: same-cycle read/write, then reset during an update
        @(negedge clk);
        bus.Pc_F = 5'd3;
        upd(5'd3, 1'b1, 5'd20, 1'b0, 5'd0);
        exp_f("t5_same", 1'b0, 5'd0);
        #1; chk_f();
        @(negedge clk);
        idle();
        exp_f("t5_next", 1'b1, 5'd20);
        #1; chk_f();
        @(negedge clk);
        upd(5'd3, 1'b1, 5'd20, 1'b1, 5'd20);
        reset = 1'b1;
        exp_f("t5_rst", 1'b0, 5'd0);
        exp_s("t5_rst", 16'd0, 16'd0);
        #1; chk_f(); chk_s();
        @(negedge clk);
        reset = 1'b0;
        idle();
        exp_f("t5_post_rst", 1'b0, 5'd0);
        exp_s("t5_post_rst", 16'd0, 16'd0);
        #1; chk_f(); chk_s();
        @(negedge clk);
        upd(5'd3, 1'b1, 5'd20, 1'b0, 5'd0);
        @(negedge clk);
        idle();
        exp_f("t5_init_T", 1'b1, 5'd20);
        #1; chk_f();
        @(negedge clk);
        upd(5'd3, 1'b0, 5'd20, 1'b1, 5'd20);
        @(negedge clk);
        idle();
        exp_f("t5_init_TN", 1'b0, 5'd20);
        exp_s("t5_stats", 16'd2, 16'd2);
        #1; chk_f(); chk_s();

        // 6: statistics saturation
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        upd(5'd9, 1'b0, 5'd0, 1'b1, 5'd0);
        repeat (65534) @(posedge clk);
        @(negedge clk);
        idle();
        exp_s("t6_preload", 16'hFFFE, 16'hFFFE);
        #1; chk_s();
        @(negedge clk);
        upd(5'd9, 1'b0, 5'd0, 1'b1, 5'd0);
        exp_e("t6_mis", 1'b1, 5'd10, 1'b1);
        #1; chk_e();
        @(negedge clk);
        exp_s("t6_sat1", 16'hFFFF, 16'hFFFF);
        #1; chk_s();
        @(negedge clk);
        @(negedge clk);
        idle();
        exp_s("t6_sat3", 16'hFFFF, 16'hFFFF);
        #1; chk_s();

        n_checks++;
        assert (q_val.size() == 0) else begin
            n_errors++;
            $error("FAIL scoreboard_leftover: observed=%0d expected=0", q_val.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
